// File: rtl/basys3_kypd_pkg.sv
// basys3_kypd_pkg: shared state type, matrix geometry and key decode for the Pmod KYPD scanner
//   NUM_COLS/NUM_ROWS : keypad matrix dimensions
//   kypd_state_e      : debounce FSM states
//   KEYMAP/key_decode : key index (row*4+col) to printed hex legend
package basys3_kypd_pkg;
  localparam int NUM_COLS = 4;
  localparam int NUM_ROWS = 4;
  typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED, RELEASE} kypd_state_e;
  // entry 0 is the top-left key; rows read 1 2 3 A / 4 5 6 B / 7 8 9 C / 0 F E D
  localparam logic [15:0][3:0] KEYMAP = {
    4'hD, 4'hE, 4'hF, 4'h0,
    4'hC, 4'h9, 4'h8, 4'h7,
    4'hB, 4'h6, 4'h5, 4'h4,
    4'hA, 4'h3, 4'h2, 4'h1
  };
  function automatic logic [3:0] key_decode(input logic [3:0] idx);
    return KEYMAP[idx];
  endfunction
endpackage

// File: rtl/basys3_sync2.sv
// basys3_sync2: two-flop synchronizer for asynchronous inputs
//   clk_i  : destination clock
//   rst_ni : asynchronous active-low reset, both stages load RST_VAL
//   d_i    : asynchronous input bus
//   q_o    : synchronized output, two clk_i cycles behind d_i
module basys3_sync2 #(
  parameter int WIDTH = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);
  logic [WIDTH-1:0] meta;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) {q_o, meta} <= {RST_VAL, RST_VAL};
    else         {q_o, meta} <= {meta, d_i};
endmodule

// File: rtl/basys3_keypad_scanner.sv
// basys3_keypad_scanner: column-strobed 4x4 keypad scan with scan-level debounce and hex decode
//   clk_1k_i    : 1 kHz system clock
//   rst_ni      : asynchronous active-low reset
//   col_o       : active-low column strobes, exactly one low
//   row_i       : active-low row returns, asynchronous
//   key_valid_o : one-cycle pulse on each newly accepted press
//   key_code_o  : hex legend of the last accepted key
//   key_held_o  : high while the accepted key is considered pressed
module basys3_keypad_scanner
  import basys3_kypd_pkg::*;
#(
  parameter int COL_CYCLES     = 2,
  parameter int DEBOUNCE_SCANS = 3
) (
  input  logic                clk_1k_i,
  input  logic                rst_ni,
  output logic [NUM_COLS-1:0] col_o,
  input  logic [NUM_ROWS-1:0] row_i,
  output logic                key_valid_o,
  output logic [3:0]          key_code_o,
  output logic                key_held_o
);
  localparam int SW = COL_CYCLES > 1 ? $clog2(COL_CYCLES) : 1;
  localparam int CW = $clog2(DEBOUNCE_SCANS + 2);
  logic [NUM_ROWS-1:0] row_s;
  logic [SW-1:0] slot;
  logic [1:0] col;
  logic last_slot;
  logic [2:0] tag_d1, tag_d2;
  logic [15:0] press_map;
  logic scan_done;
  logic hit;
  logic [3:0] hit_idx;
  kypd_state_e state, state_n;
  logic [3:0] cand, cand_n;
  logic [CW-1:0] cnt, cnt_n, cnt_inc;
  logic accept, release_done;

  basys3_sync2 #(.WIDTH(NUM_ROWS), .RST_VAL(4'hF)) u_row_sync (
    .clk_i (clk_1k_i),
    .rst_ni(rst_ni),
    .d_i   (row_i),
    .q_o   (row_s)
  );

  assign last_slot = slot == SW'(COL_CYCLES - 1);
  assign col_o     = ~(4'b0001 << col);
  assign cnt_inc   = cnt + 1'b1;

  // The {last-slot, column} tag is delayed two cycles so the map is written with
  // the synchronized rows that were on the pins during the slot's last cycle.
  always_ff @(posedge clk_1k_i or negedge rst_ni)
    if (!rst_ni) begin
      slot      <= '0;
      col       <= '0;
      tag_d1    <= '0;
      tag_d2    <= '0;
      press_map <= '0;
      scan_done <= 1'b0;
    end else begin
      slot      <= last_slot ? '0 : slot + 1'b1;
      col       <= last_slot ? col + 1'b1 : col;
      tag_d1    <= {last_slot, col};
      tag_d2    <= tag_d1;
      if (tag_d2[2]) press_map[{tag_d2[1:0], 2'b00} +: 4] <= ~row_s;
      scan_done <= tag_d2[2] && tag_d2[1:0] == 2'd3;
    end

  // Map bit is col*4+row; the key index is row*4+col, so swap the two halves.
  always_comb begin
    hit_idx = '0;
    for (int i = 0; i < 16; i++)
      if (press_map[i]) hit_idx = {i[1:0], i[3:2]};
  end
  // Exactly one bit set; zero or several keys count as no candidate.
  assign hit = press_map != '0 && (press_map & (press_map - 16'd1)) == '0;

  always_comb begin
    state_n      = state;
    cand_n       = cand;
    cnt_n        = cnt;
    accept       = 1'b0;
    release_done = 1'b0;
    if (scan_done)
      case (state)
        IDLE:
          if (hit) begin
            cand_n  = hit_idx;
            cnt_n   = CW'(1);
            accept  = DEBOUNCE_SCANS == 1;
            state_n = accept ? PRESSED : DEBOUNCE;
          end
        DEBOUNCE:
          if (hit && hit_idx == cand) begin
            cnt_n   = cnt_inc;
            accept  = cnt_inc == CW'(DEBOUNCE_SCANS);
            state_n = accept ? PRESSED : DEBOUNCE;
          end else state_n = IDLE;
        PRESSED:
          if (!(hit && hit_idx == cand)) begin
            state_n = RELEASE;
            cnt_n   = CW'(1);
          end
        RELEASE:
          if (!hit) begin
            cnt_n        = cnt_inc;
            release_done = cnt_inc >= CW'(DEBOUNCE_SCANS);
            state_n      = release_done ? IDLE : RELEASE;
          end else if (hit_idx == cand) state_n = PRESSED;
          else cnt_n = CW'(1);
        default: state_n = IDLE;
      endcase
  end

  always_ff @(posedge clk_1k_i or negedge rst_ni)
    if (!rst_ni) begin
      state       <= IDLE;
      cand        <= '0;
      cnt         <= '0;
      key_valid_o <= 1'b0;
      key_code_o  <= 4'h0;
      key_held_o  <= 1'b0;
    end else begin
      state       <= state_n;
      cand        <= cand_n;
      cnt         <= cnt_n;
      key_valid_o <= accept;
      if (accept) key_code_o <= key_decode(cand_n);
      key_held_o  <= accept | (key_held_o & ~release_done);
    end
endmodule

// File: tb/tb_basys3_keypad_scanner.sv
// tb_basys3_keypad_scanner: randomized and directed scan-level checks against a keypad/debounce model
module tb_basys3_keypad_scanner;
  localparam int D = 3;
  logic clk_1k_i = 1'b0;
  logic rst_ni = 1'b1;
  logic [3:0] col_o, row_i, key_code_o;
  logic key_valid_o, key_held_o;
  logic [15:0] keys = '0;
  logic [15:0] m = '0;
  int n_tests = 0;
  int n_fail = 0;
  int ncyc = 0;
  int r;
  logic [3:0] kmap [16] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                            4'h7, 4'h8, 4'h9, 4'hC, 4'h0, 4'hF, 4'hE, 4'hD};
  logic held, pend_ok, pend_valid, pend_held, disp_held;
  logic [3:0] acc_code, pend_code, disp_code;
  int held_key, streak_key, streak_len, quiet;

  basys3_keypad_scanner #(.COL_CYCLES(2), .DEBOUNCE_SCANS(D)) dut (
    .clk_1k_i   (clk_1k_i),
    .rst_ni     (rst_ni),
    .col_o      (col_o),
    .row_i      (row_i),
    .key_valid_o(key_valid_o),
    .key_code_o (key_code_o),
    .key_held_o (key_held_o)
  );

  always #5 clk_1k_i = ~clk_1k_i;

  // Physical keypad: a pressed key shorts its row to its column.
  always_comb begin
    row_i = 4'hF;
    for (int rr = 0; rr < 4; rr++)
      for (int c = 0; c < 4; c++)
        if (!col_o[c] && keys[rr*4+c]) row_i[rr] = 1'b0;
  end

  function automatic logic [15:0] key(input int i);
    return 16'(1) << i;
  endfunction

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at cycle %0d", tag, got, exp, ncyc);
    end
  endtask

  task automatic model_reset();
    held = 0; held_key = -1; streak_key = -1; streak_len = 0; quiet = 0;
    acc_code = 4'h0; pend_ok = 0; pend_valid = 0; pend_held = 0; pend_code = 4'h0;
    disp_code = 4'h0; disp_held = 0;
  endtask

  // One full scan of a stable key set, judged by the press/release rules.
  task automatic model_step(input logic [15:0] mask);
    int cand;
    cand = -1;
    if ($countones(mask) == 1)
      for (int i = 0; i < 16; i++) if (mask[i]) cand = i;
    pend_valid = 0;
    if (!held) begin
      if (streak_len > 0) streak_len = (cand == streak_key) ? streak_len + 1 : 0;
      else if (cand >= 0) begin streak_key = cand; streak_len = 1; end
      if (streak_len == D) begin
        held = 1; held_key = cand; streak_len = 0; quiet = 0;
        pend_valid = 1; acc_code = kmap[cand];
      end
    end else begin
      if (cand == held_key) quiet = 0;
      else if (quiet == 0 || cand >= 0) quiet = 1;
      else quiet++;
      if (quiet >= D) begin held = 0; quiet = 0; end
    end
    pend_held = held;
    pend_code = acc_code;
    pend_ok = 1;
  endtask

  // Called at a negedge on a scan boundary; the previous scan's verdict shows on cycle 3.
  task automatic run_scan(input logic [15:0] mask, input int cycles = 8);
    logic [3:0] ec;
    keys = mask;
    for (int k = 1; k <= cycles; k++) begin
      @(posedge clk_1k_i); ncyc++;
      @(negedge clk_1k_i);
      ec = ~(4'b0001 << ((ncyc / 2) % 4));
      check("col", col_o, ec);
      if (k == 3 && pend_ok) begin
        disp_code = pend_code; disp_held = pend_held; pend_ok = 0;
        check("valid_pulse", key_valid_o, pend_valid);
      end else check("valid_idle", key_valid_o, 1'b0);
      check("code", key_code_o, disp_code);
      check("held", key_held_o, disp_held);
    end
    if (cycles == 8) model_step(mask);
  endtask

  task automatic scans(input logic [15:0] mask, input int count);
    for (int i = 0; i < count; i++) run_scan(mask);
  endtask

  task automatic do_reset();
    rst_ni = 1'b0; keys = '0;
    #1;
    check("rst_col", col_o, 4'b1110);
    check("rst_valid", key_valid_o, 1'b0);
    check("rst_code", key_code_o, 4'h0);
    check("rst_held", key_held_o, 1'b0);
    repeat (2) @(posedge clk_1k_i);
    @(negedge clk_1k_i);
    check("rst_hold_col", col_o, 4'b1110);
    rst_ni = 1'b1; ncyc = 0;
    model_reset();
  endtask

  initial begin
    model_reset();
    #2 do_reset();
    scans('0, 13);
    run_scan('0, 5);
    do_reset();
    scans('0, 1); scans(key(5), 5); scans('0, 5);
    scans(key(15), 1); scans('0, 1); scans(key(15), 4); scans('0, 4);
    scans(key(3), 4); scans('0, 1); scans(key(3), 3); scans('0, 4); scans(key(3), 4); scans('0, 4);
    scans(key(0) | key(1), 4); scans(key(0), 4); scans('0, 4);
    scans(key(12), 4); scans(key(12) | key(13), 1); scans(key(13), 4); scans('0, 3);
    scans(key(13), 4); scans('0, 4);
    scans(key(12), 2);
    run_scan(key(12), 4);
    do_reset();
    scans('0, 4);
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 9);
      if (r >= 5 && r < 7) m = '0;
      else if (r >= 7 && r < 9) m = key($urandom_range(0, 15));
      else if (r == 9) m = key($urandom_range(0, 15)) | key($urandom_range(0, 15));
      run_scan(m);
    end
    scans('0, 5);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
